systolic_gemm_engine: RTL and testbench

Self-sequencing, parametrised ROWS×COLS output-stationary systolic matrix-multiply engine computing C = A·B for A (ROWS×k_len) and B (k_len×COLS). Operand banks are double-buffered, so the next job's operands load while the current job computes. An internal FSM generates the skewed operand feed, drives compute, and streams results out over a valid/ready port. It replaces externally-sequenced shift/accumulate control and the random-access accumulator readout used by the fixed 3×3 buffered array.

---
 rtl/systolic_gemm_engine_if.sv | 48 ++++
 rtl/systolic_gemm_engine.sv | 215 +++++++++++++++++++++
 tb/tb_systolic_gemm_engine.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_gemm_engine_if.sv
// systolic_gemm_engine_if: operand write, job control and result stream bundle.
// master drives operands/start/ready; slave is the engine.
interface systolic_gemm_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 8,
  parameter int ACC_WIDTH  = 32
) ();
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW  = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int KLW = $clog2(K_MAX + 1);

  logic                        a_wr_en;
  logic [RW-1:0]               a_wr_row;
  logic [KW-1:0]               a_wr_k;
  logic [DATA_WIDTH-1:0]       a_wr_data;
  logic                        b_wr_en;
  logic [CW-1:0]               b_wr_col;
  logic [KW-1:0]               b_wr_k;
  logic [DATA_WIDTH-1:0]       b_wr_data;
  logic [KLW-1:0]              k_len;
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        res_valid;
  logic                        res_ready;
  logic signed [ACC_WIDTH-1:0] res_data;
  logic [RW-1:0]               res_row;
  logic [CW-1:0]               res_col;

  modport master (
    output a_wr_en, a_wr_row, a_wr_k, a_wr_data,
    output b_wr_en, b_wr_col, b_wr_k, b_wr_data,
    output k_len, start, res_ready,
    input  busy, done, res_valid,
    input  res_data, res_row, res_col
  );

  modport slave (
    input  a_wr_en, a_wr_row, a_wr_k, a_wr_data,
    input  b_wr_en, b_wr_col, b_wr_k, b_wr_data,
    input  k_len, start, res_ready,
    output busy, done, res_valid,
    output res_data, res_row, res_col
  );
endinterface

// File: rtl/systolic_gemm_engine.sv
// systolic_gemm_engine: self-sequencing output-stationary ROWSxCOLS GEMM.
// Define SYSTOLIC_SATURATE_EN for per-add saturating accumulation.
module systolic_gemm_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_gemm_engine_if.slave gemm
);
  localparam int DW   = DATA_WIDTH;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW   = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int KLW  = $clog2(K_MAX + 1);
  localparam int LMAX = K_MAX + ROWS + COLS - 2;
  localparam int TW   = $clog2(LMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DRAIN
  } state_t;

  state_t                      state_q;
  logic                        bank_q;
  logic [TW-1:0]               t_q;
  logic [TW-1:0]               t_last_q;
  logic [KLW-1:0]              effk_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        valid_q;
  logic signed [ACC_WIDTH-1:0] res_q;
  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;

  logic signed [DW-1:0] a_mem_q [2][ROWS][K_MAX];
  logic signed [DW-1:0] b_mem_q [2][COLS][K_MAX];

  logic signed [DW-1:0] a_edge [ROWS];
  logic signed [DW-1:0] b_edge [COLS];
  logic signed [DW-1:0] a_in [ROWS][COLS];
  logic signed [DW-1:0] b_in [ROWS][COLS];
  logic signed [DW-1:0] a_pipe_q [ROWS][COLS];
  logic signed [DW-1:0] b_pipe_q [ROWS][COLS];

  logic signed [ACC_WIDTH-1:0] acc_q [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc_d [ROWS][COLS];

  logic           start_ok;
  logic           hs;
  logic           last_res;
  logic [KLW-1:0] effk_d;
  logic [TW-1:0]  t_last_d;
  logic [RW-1:0]  row_nx;
  logic [CW-1:0]  col_nx;

  assign start_ok = (state_q == IDLE) && gemm.start &&
                    (gemm.k_len != '0);
  assign effk_d   = (int'(gemm.k_len) > K_MAX) ?
                    KLW'(K_MAX) : gemm.k_len;
  assign t_last_d = TW'(effk_d) + TW'(ROWS + COLS - 3);
  assign hs       = valid_q && gemm.res_ready;
  assign last_res = (int'(row_q) == ROWS - 1) &&
                    (int'(col_q) == COLS - 1);
  assign row_nx   = row_q + 1'b1;
  assign col_nx   = col_q + 1'b1;

  assign gemm.busy      = busy_q;
  assign gemm.done      = done_q;
  assign gemm.res_valid = valid_q;
  assign gemm.res_data  = res_q;
  assign gemm.res_row   = row_q;
  assign gemm.res_col   = col_q;

  // Operand writes always land in the shadow (inactive) bank
  always_ff @(posedge clk) begin
    if (gemm.a_wr_en && int'(gemm.a_wr_row) < ROWS &&
        int'(gemm.a_wr_k) < K_MAX)
      a_mem_q[~bank_q][gemm.a_wr_row][gemm.a_wr_k] <= gemm.a_wr_data;
    if (gemm.b_wr_en && int'(gemm.b_wr_col) < COLS &&
        int'(gemm.b_wr_k) < K_MAX)
      b_mem_q[~bank_q][gemm.b_wr_col][gemm.b_wr_k] <= gemm.b_wr_data;
  end

  // Skewed edge feed: row i gets A[i][t-i], column j gets B[t-j][j]
  for (genvar i = 0; i < ROWS; i++) begin : g_aedge
    int ka;
    assign ka = int'(t_q) - i;
    assign a_edge[i] = (ka >= 0 && ka < int'(effk_q)) ?
                       a_mem_q[bank_q][i][KW'(ka)] : '0;
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bedge
    int kb;
    assign kb = int'(t_q) - j;
    assign b_edge[j] = (kb >= 0 && kb < int'(effk_q)) ?
                       b_mem_q[bank_q][j][KW'(kb)] : '0;
  end

  // PE grid: A flows right, B flows down, sum stays put
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [2*DW-1:0]      prod;
      logic signed [ACC_WIDTH-1:0] prod_x;
      logic signed [ACC_WIDTH:0]   sum;

      if (j == 0) begin : g_ae
        assign a_in[i][j] = a_edge[i];
      end else begin : g_ap
        assign a_in[i][j] = a_pipe_q[i][j-1];
      end

      if (i == 0) begin : g_be
        assign b_in[i][j] = b_edge[j];
      end else begin : g_bp
        assign b_in[i][j] = b_pipe_q[i-1][j];
      end

      assign prod   = a_in[i][j] * b_in[i][j];
      assign prod_x = ACC_WIDTH'(prod);
      assign sum    = {acc_q[i][j][ACC_WIDTH-1], acc_q[i][j]} +
                      {prod_x[ACC_WIDTH-1], prod_x};

`ifdef SYSTOLIC_SATURATE_EN
      // Clamp each add on its own; a later add may re-enter range
      assign acc_d[i][j] =
        (sum[ACC_WIDTH] == sum[ACC_WIDTH-1]) ? sum[ACC_WIDTH-1:0] :
        (sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                        : {1'b0, {(ACC_WIDTH-1){1'b1}}});
`else
      assign acc_d[i][j] = sum[ACC_WIDTH-1:0];
`endif
    end
  end

  // Accumulators and skew registers; cleared when a job is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '{default: '0};
      a_pipe_q <= '{default: '0};
      b_pipe_q <= '{default: '0};
    end else if (start_ok) begin
      acc_q    <= '{default: '0};
      a_pipe_q <= '{default: '0};
      b_pipe_q <= '{default: '0};
    end else if (state_q == COMPUTE) begin
      acc_q    <= acc_d;
      a_pipe_q <= a_in;
      b_pipe_q <= b_in;
    end
  end

  // Job sequencer with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bank_q   <= 1'b0;
      t_q      <= '0;
      t_last_q <= '0;
      effk_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q  <= COMPUTE;
            bank_q   <= ~bank_q;
            effk_q   <= effk_d;
            t_last_q <= t_last_d;
            t_q      <= '0;
            busy_q   <= 1'b1;
          end
        end
        COMPUTE: begin
          t_q <= t_q + 1'b1;
          if (t_q == t_last_q) begin
            state_q <= DRAIN;
            valid_q <= 1'b1;
            res_q   <= acc_d[0][0];
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        DRAIN: begin
          if (hs) begin
            if (last_res) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (int'(col_q) == COLS - 1) begin
              row_q <= row_nx;
              col_q <= '0;
              res_q <= acc_q[row_nx][CW'(0)];
            end else begin
              col_q <= col_nx;
              res_q <= acc_q[row_q][col_nx];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_gemm_engine.sv
// tb_systolic_gemm_engine: directed jobs for the 4x4 engine, 16-bit accumulators.
// Covers identity, backpressure, double buffering, overflow, reset, k_len edges.
module tb_systolic_gemm_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   a_m [4][8];
  int   b_m [8][4];
  int   exp_c [16];

  always #5 clk = ~clk;

  systolic_gemm_engine_if #(
    .DATA_WIDTH(8), .ROWS(4), .COLS(4), .K_MAX(8), .ACC_WIDTH(16)
  ) gemm_if ();

  systolic_gemm_engine #(
    .DATA_WIDTH(8), .ROWS(4), .COLS(4), .K_MAX(8), .ACC_WIDTH(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .gemm (gemm_if)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_all();
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 4; r++) begin
        gemm_if.a_wr_en   = 1'b1;
        gemm_if.a_wr_row  = 2'(r);
        gemm_if.a_wr_k    = 3'(k);
        gemm_if.a_wr_data = 8'(a_m[r][k]);
        gemm_if.b_wr_en   = 1'b1;
        gemm_if.b_wr_col  = 2'(r);
        gemm_if.b_wr_k    = 3'(k);
        gemm_if.b_wr_data = 8'(b_m[k][r]);
        @(negedge clk);
      end
    end
    gemm_if.a_wr_en = 1'b0;
    gemm_if.b_wr_en = 1'b0;
  endtask

  task automatic fill_const(input int av, input int bv);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++) begin
        a_m[r][k] = av;
        b_m[k][r] = bv;
      end
  endtask

  task automatic set_exp(input int v);
    for (int n = 0; n < 16; n++) exp_c[n] = v;
  endtask

  task automatic run_job(input string tag, input int klen,
                         input bit toggle, input int lat,
                         input int ec [16]);
    int cyc;
    int idx;
    bit ph;
    bit stalled;
    int held_d;
    int held_p;
    gemm_if.k_len     = 4'(klen);
    gemm_if.start     = 1'b1;
    gemm_if.res_ready = 1'b0;
    @(negedge clk);
    gemm_if.start = 1'b0;
    check({tag, "_busy"}, int'(gemm_if.busy), 1);
    cyc = 0;
    while (!gemm_if.res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, lat);
    idx = 0;
    ph = 1'b1;
    stalled = 1'b0;
    held_d = 0;
    held_p = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      if (stalled) begin
        check({tag, "_hold_v"}, int'(gemm_if.res_valid), 1);
        check({tag, "_hold_d"}, int'(gemm_if.res_data), held_d);
        check({tag, "_hold_p"},
              int'({gemm_if.res_row, gemm_if.res_col}), held_p);
      end
      gemm_if.res_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      stalled = 1'b0;
      if (gemm_if.res_valid) begin
        if (gemm_if.res_ready) begin
          check({tag, "_data"}, int'(gemm_if.res_data), ec[idx]);
          check({tag, "_row"}, int'(gemm_if.res_row), idx / 4);
          check({tag, "_col"}, int'(gemm_if.res_col), idx % 4);
          idx++;
        end else begin
          stalled = 1'b1;
          held_d = int'(gemm_if.res_data);
          held_p = int'({gemm_if.res_row, gemm_if.res_col});
        end
      end
      @(negedge clk);
      cyc++;
    end
    gemm_if.res_ready = 1'b0;
    check({tag, "_nres"}, idx, 16);
    check({tag, "_done"}, int'(gemm_if.done), 1);
    check({tag, "_busy_done"}, int'(gemm_if.busy), 0);
    check({tag, "_valid_end"}, int'(gemm_if.res_valid), 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, int'(gemm_if.done), 0);
  endtask

  initial begin
    gemm_if.a_wr_en   = 1'b0;
    gemm_if.a_wr_row  = '0;
    gemm_if.a_wr_k    = '0;
    gemm_if.a_wr_data = '0;
    gemm_if.b_wr_en   = 1'b0;
    gemm_if.b_wr_col  = '0;
    gemm_if.b_wr_k    = '0;
    gemm_if.b_wr_data = '0;
    gemm_if.k_len     = '0;
    gemm_if.start     = 1'b0;
    gemm_if.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(gemm_if.busy), 0);
    check("rst_done", int'(gemm_if.done), 0);
    check("rst_valid", int'(gemm_if.res_valid), 0);
    check("rst_data", int'(gemm_if.res_data), 0);
    check("rst_row", int'(gemm_if.res_row), 0);
    check("rst_col", int'(gemm_if.res_col), 0);
    rst = 1'b0;
    @(negedge clk);

    // identity A, B[k][j]=4k+j+1; k>=4 holds junk that must be ignored
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++) begin
        a_m[r][k] = (k < 4) ? ((r == k) ? 1 : 0) : 7;
        b_m[k][r] = (k < 4) ? (4 * k + r + 1) : 5;
      end
    for (int n = 0; n < 16; n++) exp_c[n] = n + 1;
    load_all();
    run_job("ident", 4, 1'b0, 10, exp_c);

    load_all();
    run_job("bp", 4, 1'b1, 10, exp_c);

    // job1 all-ones x all-twos; shadow gets A=3 while it runs
    fill_const(1, 2);
    load_all();
    set_exp(16);
    fill_const(3, 2);
    fork
      run_job("db1", 8, 1'b0, 14, exp_c);
      begin
        repeat (2) @(negedge clk);
        load_all();
      end
    join
    set_exp(48);
    run_job("db2", 8, 1'b0, 14, exp_c);

    fill_const(-128, -128);
    load_all();
`ifdef SYSTOLIC_SATURATE_EN
    set_exp(32767);
`else
    set_exp(0);
`endif
    run_job("ovf", 8, 1'b0, 14, exp_c);

    gemm_if.k_len = 4'd0;
    gemm_if.start = 1'b1;
    @(negedge clk);
    gemm_if.start = 1'b0;
    check("k0_busy", int'(gemm_if.busy), 0);
    repeat (3) @(negedge clk);
    check("k0_valid", int'(gemm_if.res_valid), 0);
    check("k0_busy_late", int'(gemm_if.busy), 0);

    fill_const(1, 2);
    load_all();
    set_exp(16);
    run_job("k12", 12, 1'b0, 14, exp_c);

    // abandon a job at t=5, then run a fresh one
    load_all();
    gemm_if.k_len = 4'd8;
    gemm_if.start = 1'b1;
    @(negedge clk);
    gemm_if.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", int'(gemm_if.busy), 0);
    check("mrst_valid", int'(gemm_if.res_valid), 0);
    check("mrst_done", int'(gemm_if.done), 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gemm_if.done || gemm_if.res_valid)
        check("mrst_quiet", 1, 0);
    end
    load_all();
    set_exp(16);
    run_job("fresh", 8, 1'b0, 14, exp_c);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
